// File: rtl/nv_nvdla_noc_pkg.sv
// Shared types for the NoC-side AXI write responder: AXI field widths and the AW command entry.
package nv_nvdla_noc_pkg;

  localparam int AXI_ID_W  = 8;
  localparam int AXI_LEN_W = 4;
  localparam int B_DELAY_W = 4;

  typedef struct packed {
    logic [AXI_ID_W-1:0]  id;
    logic [AXI_LEN_W-1:0] len;
  } aw_entry_t;

endpackage

// File: rtl/nv_nvdla_noc_sync_fifo.sv
// Single-clock FIFO with full/empty/count flags. No bypass: a push on a full FIFO is dropped
// even if a pop happens in the same cycle. `peek` is the entry behind the head.
module nv_nvdla_noc_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [W-1:0]     peek,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign peek    = mem[rd_ptr + PTR_W'(1)];

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/nv_nvdla_noc_wr_bresp_gen.sv
// Memory-side AXI write responder: queues AW commands, counts W beats per burst and returns
// in-order B responses after a programmable minimum delay.
module nv_nvdla_noc_wr_bresp_gen
  import nv_nvdla_noc_pkg::*;
#(
  parameter int AW_DEPTH = 4,
  parameter int B_DEPTH  = 4,
  parameter int B_DELAY  = 2
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                mcif2noc_axi_aw_awvalid,
  output logic                mcif2noc_axi_aw_awready,
  input  logic [AXI_ID_W-1:0] mcif2noc_axi_aw_awid,
  input  logic [AXI_LEN_W-1:0] mcif2noc_axi_aw_awlen,
  input  logic                mcif2noc_axi_w_wvalid,
  output logic                mcif2noc_axi_w_wready,
  input  logic                mcif2noc_axi_w_wlast,
  output logic                noc2mcif_axi_b_bvalid,
  input  logic                noc2mcif_axi_b_bready,
  output logic [AXI_ID_W-1:0] noc2mcif_axi_b_bid,
  output logic [3:0]          bresp_pending_cnt,
  output logic                wlast_err
);

  localparam int AW_CNT_W = $clog2(AW_DEPTH) + 1;
  localparam int B_CNT_W  = $clog2(B_DEPTH) + 1;
  localparam logic [B_DELAY_W-1:0] B_DELAY_V = B_DELAY_W'(B_DELAY);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
  // a source keeps valid and payload stable until it sees ready (B held while bvalid && !bready).

  aw_entry_t              aw_din;
  aw_entry_t              aw_head;
  aw_entry_t              aw_peek_unused;
  logic                   aw_push;
  logic                   aw_pop;
  logic                   aw_full;
  logic                   aw_empty;
  logic [AW_CNT_W-1:0]    aw_count_unused;

  logic [AXI_ID_W-1:0]    b_head;
  logic [AXI_ID_W-1:0]    b_peek;
  logic                   b_push;
  logic                   b_pop;
  logic                   b_full;
  logic                   b_empty;
  logic [B_CNT_W-1:0]     b_count;
  logic                   b_head_new;

  logic [AXI_LEN_W-1:0]   beat_cnt;
  logic [B_DELAY_W-1:0]   dly_cnt;
  logic                   w_fire;
  logic                   burst_done;
  logic                   bvalid_q;
  logic                   bvalid_nxt;
  logic [AXI_ID_W-1:0]    bid_q;
  logic [AXI_ID_W-1:0]    bid_nxt;
  logic                   wlast_err_q;

  assign aw_din                  = '{id: mcif2noc_axi_aw_awid, len: mcif2noc_axi_aw_awlen};
  assign mcif2noc_axi_aw_awready = ~aw_full;
  assign aw_push                 = mcif2noc_axi_aw_awvalid & ~aw_full;

  assign mcif2noc_axi_w_wready = ~aw_empty & ~b_full;
  assign w_fire                = mcif2noc_axi_w_wvalid & mcif2noc_axi_w_wready;
  assign burst_done            = (beat_cnt == aw_head.len);
  assign aw_pop                = w_fire & burst_done;
  assign b_push                = aw_pop;
  assign b_pop                 = bvalid_q & noc2mcif_axi_b_bready;

  // A fresh head appears on a push into an empty FIFO, or on a pop that leaves an entry behind.
  assign b_head_new = (b_push & b_empty) | (b_pop & ((b_count > B_CNT_W'(1)) | b_push));

  nv_nvdla_noc_sync_fifo #(.W($bits(aw_entry_t)), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .push            (aw_push),
    .pop             (aw_pop),
    .din             (aw_din),
    .dout            (aw_head),
    .peek            (aw_peek_unused),
    .full            (aw_full),
    .empty           (aw_empty),
    .count           (aw_count_unused)
  );

  nv_nvdla_noc_sync_fifo #(.W(AXI_ID_W), .DEPTH(B_DEPTH)) u_b_fifo (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .push            (b_push),
    .pop             (b_pop),
    .din             (aw_head.id),
    .dout            (b_head),
    .peek            (b_peek),
    .full            (b_full),
    .empty           (b_empty),
    .count           (b_count)
  );

  // On a pop the next response can only follow immediately when it needs no delay; its ID
  // comes from the entry behind the head, or straight from a same-cycle completion.
  always_comb begin
    bvalid_nxt = 1'b0;
    bid_nxt    = bid_q;
    if (bvalid_q && !noc2mcif_axi_b_bready) begin
      bvalid_nxt = 1'b1;
    end else if (b_pop) begin
      if ((B_DELAY == 0) && ((b_count > B_CNT_W'(1)) || b_push)) begin
        bvalid_nxt = 1'b1;
        bid_nxt    = (b_count > B_CNT_W'(1)) ? b_peek : aw_head.id;
      end
    end else if (!b_empty && (dly_cnt == '0)) begin
      bvalid_nxt = 1'b1;
      bid_nxt    = b_head;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      beat_cnt    <= '0;
      dly_cnt     <= '0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      if (w_fire) begin
        beat_cnt <= burst_done ? '0 : beat_cnt + AXI_LEN_W'(1);
        if (mcif2noc_axi_w_wlast != burst_done) wlast_err_q <= 1'b1;
      end
      if (b_head_new)          dly_cnt <= B_DELAY_V;
      else if (dly_cnt != '0)  dly_cnt <= dly_cnt - B_DELAY_W'(1);
      bvalid_q <= bvalid_nxt;
      bid_q    <= bid_nxt;
    end
  end

  assign noc2mcif_axi_b_bvalid = bvalid_q;
  assign noc2mcif_axi_b_bid    = bid_q;
  assign wlast_err             = wlast_err_q;

  generate
    if (B_CNT_W > 4) begin : g_cnt_sat
      assign bresp_pending_cnt = (b_count > B_CNT_W'(15)) ? 4'hf : b_count[3:0];
    end else begin : g_cnt_ext
      assign bresp_pending_cnt = 4'(b_count);
    end
  endgenerate

endmodule

// File: tb/tb_nv_nvdla_noc_wr_bresp_gen.sv
// Directed bench for nv_nvdla_noc_wr_bresp_gen: table of single bursts plus hand-written
// sequences for streaming, B backpressure, AW full and reset mid-burst.
module tb_nv_nvdla_noc_wr_bresp_gen;

  localparam int EXP_LAT = 3;    // completing beat edge to bvalid edge with B_DELAY=2
  localparam int BUDGET  = 200;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       awvalid = 1'b0;
  logic       awready;
  logic [7:0] awid    = '0;
  logic [3:0] awlen   = '0;
  logic       wvalid  = 1'b0;
  logic       wready;
  logic       wlast   = 1'b0;
  logic       bvalid;
  logic       bready  = 1'b1;
  logic [7:0] bid;
  logic [3:0] pend;
  logic       err;

  nv_nvdla_noc_wr_bresp_gen #(.AW_DEPTH(4), .B_DEPTH(4), .B_DELAY(2)) dut (
    .nvdla_core_clk          (clk),
    .nvdla_core_rstn         (rstn),
    .mcif2noc_axi_aw_awvalid (awvalid),
    .mcif2noc_axi_aw_awready (awready),
    .mcif2noc_axi_aw_awid    (awid),
    .mcif2noc_axi_aw_awlen   (awlen),
    .mcif2noc_axi_w_wvalid   (wvalid),
    .mcif2noc_axi_w_wready   (wready),
    .mcif2noc_axi_w_wlast    (wlast),
    .noc2mcif_axi_b_bvalid   (bvalid),
    .noc2mcif_axi_b_bready   (bready),
    .noc2mcif_axi_b_bid      (bid),
    .bresp_pending_cnt       (pend),
    .wlast_err               (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: no handshake within %0d cycles (cycle %0d)", name, BUDGET, cyc);
  endtask

  // scoreboard
  logic [7:0] exp_q[$];
  int         done_q[$];
  int         last_done    = 0;
  int         last_aw_edge = 0;
  int         b_edge_last  = 0;
  int         b_seen       = 0;
  logic       hold_bvalid  = 1'b0;
  logic [7:0] hold_bid     = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      hold_bvalid <= 1'b0;
    end else begin
      if (hold_bvalid) begin
        check("bvalid_held", bvalid, 1'b1);
        check("bid_held", bid, hold_bid);
      end
      if (bvalid && bready) begin
        b_seen++;
        b_edge_last = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL b_unexpected: got bid 0x%0h, expected no response (cycle %0d)", bid, cyc);
        end else begin
          logic [7:0] e;
          int t;
          e = exp_q.pop_front();
          t = done_q.pop_front();
          check("b_order_bid", bid, e);
          check("b_min_latency", (cyc - t) >= EXP_LAT, 1'b1);
        end
      end
      hold_bvalid <= bvalid && !bready;
      hold_bid    <= bid;
    end
  end

  // drivers: every task is entered and left just after a rising edge
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; bready = 1'b1; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    exp_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [3:0] len);
    int n = 0;
    awvalid = 1'b1; awid = id; awlen = len;
    while (!awready && n < BUDGET) begin
      sync();
      n++;
    end
    if (!awready) begin
      timeout("aw_wait");
      awvalid = 1'b0;
      return;
    end
    last_aw_edge = cyc + 1;
    sync();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] id, input logic [3:0] len,
                        input logic [15:0] mask, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      int n = 0;
      wvalid = 1'b1;
      wlast  = mask[i];
      while (!wready && n < BUDGET) begin
        sync();
        n++;
      end
      if (!wready) begin
        timeout("w_wait");
        wvalid = 1'b0;
        return;
      end
      if (i == int'(len)) begin
        exp_q.push_back(id);
        done_q.push_back(cyc + 1);
        last_done = cyc + 1;
      end
      sync();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      timeout("b_drain");
      exp_q.delete();
      done_q.delete();
    end
    sync();
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  id;
    logic [3:0]  len;
    logic [15:0] mask;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int seen0;
    logic [7:0] pat_err[3];
    vecs[0] = '{8'h03, 4'd0,  16'h0001, 1'b0};
    vecs[1] = '{8'h5a, 4'd1,  16'h0002, 1'b0};
    vecs[2] = '{8'ha5, 4'd15, 16'h8000, 1'b0};
    vecs[3] = '{8'hc3, 4'd2,  16'h0004, 1'b0};
    vecs[4] = '{8'h11, 4'd2,  16'h0006, 1'b1};
    vecs[5] = '{8'h22, 4'd0,  16'h0001, 1'b1};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_awready", awready, 1'b1);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_bid", bid, 8'h00);
    check("rst_wlast_err", err, 1'b0);
    check("rst_pending", pend, 4'd0);
    sync();
    rstn = 1'b1;

    // table of isolated bursts with bready=1
    for (int i = 0; i < 6; i++) begin
      send_aw(vecs[i].id, vecs[i].len);
      send_w(vecs[i].id, vecs[i].len, vecs[i].mask, int'(vecs[i].len) + 1);
      wait_drain();
      check("vec_latency", b_edge_last - last_done, EXP_LAT);
      check("vec_bvalid_pulse", bvalid, 1'b0);
      check("vec_wlast_err", err, vecs[i].exp_err);
      check("vec_pending", pend, 4'd0);
      sync();
    end

    // wlast error sets on the 2nd beat and stays set
    do_reset();
    send_aw(8'h11, 4'd2);
    pat_err = '{8'h00, 8'h01, 8'h01};
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      wvalid = 1'b1;
      wlast  = (i != 0);
      while (!wready && n < BUDGET) begin
        sync();
        n++;
      end
      if (i == 2) begin
        exp_q.push_back(8'h11);
        done_q.push_back(cyc + 1);
      end
      sync();
      wvalid = 1'b0;
      @(negedge clk);
      check("wlast_err_step", err, pat_err[i][0]);
      sync();
    end
    wait_drain();
    check("wlast_err_sticky", err, 1'b1);
    sync();

    // four streamed bursts, ids 0..3, len 3
    do_reset();
    seen0 = b_seen;
    fork
      for (int k = 0; k < 4; k++) send_aw(8'(k), 4'd3);
      for (int k = 0; k < 4; k++) send_w(8'(k), 4'd3, 16'h0008, 4);
    join
    wait_drain();
    check("stream_b_count", b_seen - seen0, 4);
    check("stream_pending", pend, 4'd0);
    check("stream_wlast_err", err, 1'b0);
    sync();

    // B backpressure: B FIFO fills, 5th beat stalls until bready rises
    do_reset();
    bready = 1'b0;
    seen0 = b_seen;
    for (int k = 0; k < 4; k++) begin
      send_aw(8'h10 + 8'(k), 4'd0);
      send_w(8'h10 + 8'(k), 4'd0, 16'h0001, 1);
    end
    send_aw(8'h14, 4'd0);
    fork
      send_w(8'h14, 4'd0, 16'h0001, 1);
      begin
        repeat (4) @(negedge clk);
        check("bp_wready", wready, 1'b0);
        check("bp_pending", pend, 4'd4);
        check("bp_bvalid", bvalid, 1'b1);
        check("bp_bid", bid, 8'h10);
        sync();
        bready = 1'b1;
      end
    join
    wait_drain();
    check("bp_b_count", b_seen - seen0, 5);
    check("bp_pending_end", pend, 4'd0);
    sync();

    // AW full: 5th AW accepted the cycle after the first burst completes
    do_reset();
    for (int k = 0; k < 4; k++) send_aw(8'h20 + 8'(k), 4'd1);
    @(negedge clk);
    check("awfull_awready", awready, 1'b0);
    sync();
    fork
      send_aw(8'h24, 4'd0);
      send_w(8'h20, 4'd1, 16'h0002, 2);
    join
    check("awfull_accept_edge", last_aw_edge - last_done, 1);
    for (int k = 1; k < 4; k++) send_w(8'h20 + 8'(k), 4'd1, 16'h0002, 2);
    send_w(8'h24, 4'd0, 16'h0001, 1);
    wait_drain();
    check("awfull_pending_end", pend, 4'd0);
    sync();

    // reset after 2 of 4 beats; only the following burst responds
    do_reset();
    seen0 = b_seen;
    send_aw(8'h30, 4'd3);
    send_w(8'h30, 4'd3, 16'h0008, 2);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_awready", awready, 1'b1);
    check("midrst_wready", wready, 1'b0);
    check("midrst_bvalid", bvalid, 1'b0);
    check("midrst_pending", pend, 4'd0);
    sync();
    rstn = 1'b1;
    send_aw(8'h07, 4'd0);
    send_w(8'h07, 4'd0, 16'h0001, 1);
    wait_drain();
    repeat (10) @(negedge clk);
    check("midrst_b_count", b_seen - seen0, 1);
    check("midrst_wlast_err", err, 1'b0);

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule
